// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
//   Bundles the request, response and data-memory signals of the load/store
//   unit.
//   slave  : the load/store unit's view. It takes requests and memory
//            replies, and drives the response and memory access.
//   master : the surrounding datapath/memory view. It drives requests and
//            memory replies.
//   Signals:
//     req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata - request
//     resp_valid/resp_rdata/resp_err                           - completion
//     busy                                                     - pc stall
//     mem_valid/mem_we/mem_addr/mem_wstrb/mem_wdata            - memory access
//     mem_ready/mem_rdata                                      - memory reply
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic [1:0]            resp_err;
  logic                  busy;
  logic                  mem_valid;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Takes one load/store request at a time from the RISC-V datapath. It checks
//   size and alignment, issues one word-aligned memory access with byte
//   strobes, and waits for mem_ready or a timeout. It then returns one response
//   pulse carrying lane-aligned, sign- or zero-extended load data.
//   Ports:
//     clk      - rising-edge clock
//     reset_n  - asynchronous active-low reset
//     bus      - load_store_unit_if.slave, which carries the request, response,
//                busy and memory signals
//   Error codes on resp_err: 00 ok, 01 misaligned, 10 timeout, 11 illegal size.
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  load_store_unit_if.slave   bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Byte strobes covering 'bytes' lanes starting at lane 'off'.
  function automatic logic [STRB_W-1:0] lane_strb(input logic [OFF_W-1:0] off,
                                                  input logic [1:0]       size);
    logic [STRB_W-1:0] res;
    int o;
    int n;
    o = int'(off);
    n = 1 << size;
    for (int i = 0; i < STRB_W; i++) res[i] = (i >= o) && (i < o + n);
    return res;
  endfunction

  // Right-align the addressed lane and extend to full width.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                    input logic [OFF_W-1:0]  off,
                                                    input logic [1:0]        size,
                                                    input logic              uns);
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] res;
    logic              sign;
    int                nb;
    s  = raw >> {off, 3'b000};
    nb = 8 << size;
    case (size)
      2'd0:    sign = s[7];
      2'd1:    sign = s[15];
      2'd2:    sign = s[31];
      default: sign = s[DATA_W-1];
    endcase
    if (uns) sign = 1'b0;
    for (int i = 0; i < DATA_W; i++) res[i] = (i < nb) ? s[i] : sign;
    return res;
  endfunction

  logic [1:0]       req_size;
  logic [OFF_W-1:0] req_off;
  logic [OFF_W-1:0] size_mask;
  logic             req_illegal;
  logic             req_misaligned;
  logic             in_access;
  logic             in_store;

  assign req_size  = bus.req_funct3[1:0];
  assign req_off   = bus.req_addr[OFF_W-1:0];
  // The mask is only meaningful for legal sizes; illegal sizes are rejected first.
  assign size_mask = OFF_W'((32'd1 << req_size) - 32'd1);
  assign req_illegal    = (bus.req_funct3 == 3'b111) || ((DATA_W == 32) && (req_size == 2'b11));
  assign req_misaligned = (req_off & size_mask) != '0;

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          rdata_d  = '0;
          cnt_d    = '0;
          if (req_illegal) begin
            err_d   = 2'b11;
            state_d = S_DONE;
          end else if (req_misaligned) begin
            err_d   = 2'b01;
            state_d = S_DONE;
          end else begin
            err_d   = 2'b00;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // mem_ready takes priority over a timeout expiring in the same cycle.
        if (bus.mem_ready) begin
          rdata_d = we_q ? '0 : load_extend(bus.mem_rdata, addr_q[OFF_W-1:0],
                                            funct3_q[1:0], funct3_q[2]);
          err_d   = 2'b00;
          state_d = S_DONE;
        end else if ((TIMEOUT_CYC != 0) && (int'(cnt_q) == TIMEOUT_CYC - 1)) begin
          err_d   = 2'b10;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Memory outputs are driven only while an access is outstanding. Because
  // they come straight from the state register, an asynchronous reset drops
  // mem_valid at once.
  assign in_access     = (state_q == S_ACCESS);
  assign in_store      = in_access && we_q;
  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.resp_rdata = (state_q == S_DONE) ? rdata_q : '0;
  assign bus.resp_err   = (state_q == S_DONE) ? err_q : '0;
  assign bus.mem_valid  = in_access;
  assign bus.mem_we     = in_store;
  assign bus.mem_addr   = in_access ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus.mem_wstrb  = in_store ? lane_strb(addr_q[OFF_W-1:0], funct3_q[1:0]) : '0;
  assign bus.mem_wdata  = in_store ? (wdata_q << {addr_q[OFF_W-1:0], 3'b000}) : '0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) b32 ();
  load_store_unit_if #(.ADDR_W(32), .DATA_W(64)) b64 ();

  load_store_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut32 (
    .clk(clk), .reset_n(reset_n), .bus(b32));
  load_store_unit #(.ADDR_W(32), .DATA_W(64), .TIMEOUT_CYC(16)) dut64 (
    .clk(clk), .reset_n(reset_n), .bus(b64));

  typedef struct {
    string       nm;
    logic [63:0] rdata;
    logic [1:0]  err;
    int          cyc;
    int          mv;
    logic        we;
    logic [31:0] maddr;
    logic [7:0]  strb;
    logic [63:0] mwd;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          wait_c[2];
  bit          stuck[2];
  logic [63:0] memrd[2];
  int          mvc[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic int qsize(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  // Monitor and memory responder for one DUT, evaluated on the falling edge.
  task automatic mon(input int s, input logic rv, input logic [63:0] rrd, input logic [1:0] rerr,
                     input logic mvld, input logic mwe, input logic [31:0] maddr,
                     input logic [7:0] strb, input logic [63:0] mwd, output logic rdy);
    exp_t e;
    rdy = 1'b0;
    if (rv) begin
      if (qsize(s) == 0) chk("unexpected_resp", 64'd1, 64'd0);
      else begin
        if (s == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk({e.nm, "_rdata"}, rrd, e.rdata);
        chk({e.nm, "_err"}, 64'(rerr), 64'(e.err));
        chk({e.nm, "_lat"}, 64'(cyc), 64'(e.cyc));
        chk({e.nm, "_memcycles"}, 64'(mvc[s]), 64'(e.mv));
      end
      mvc[s] = 0;
    end
    if (mvld) begin
      mvc[s]++;
      if (!stuck[s] && (mvc[s] - 1 == wait_c[s])) begin
        rdy = 1'b1;
        if (qsize(s) != 0) begin
          if (s == 0) e = q0[0]; else e = q1[0];
          chk({e.nm, "_maddr"}, 64'(maddr), 64'(e.maddr));
          chk({e.nm, "_mwe"}, 64'(mwe), 64'(e.we));
          chk({e.nm, "_wstrb"}, 64'(strb), 64'(e.strb));
          if (e.we) chk({e.nm, "_mwdata"}, mwd, e.mwd);
        end
      end
    end
  endtask

  always @(negedge clk) begin : mon32
    logic r;
    if (!reset_n) begin
      mvc[0] = 0;
      b32.mem_ready = 1'b0;
    end else begin
      mon(0, b32.resp_valid, 64'(b32.resp_rdata), b32.resp_err, b32.mem_valid, b32.mem_we,
          b32.mem_addr, 8'(b32.mem_wstrb), 64'(b32.mem_wdata), r);
      b32.mem_ready = r;
      b32.mem_rdata = memrd[0][31:0];
    end
  end

  always @(negedge clk) begin : mon64
    logic r;
    if (!reset_n) begin
      mvc[1] = 0;
      b64.mem_ready = 1'b0;
    end else begin
      mon(1, b64.resp_valid, b64.resp_rdata, b64.resp_err, b64.mem_valid, b64.mem_we,
          b64.mem_addr, b64.mem_wstrb, b64.mem_wdata, r);
      b64.mem_ready = r;
      b64.mem_rdata = memrd[1];
    end
  end

  task automatic issue(input int s, input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [63:0] wd, input int w, input bit stk,
                       input logic [63:0] mrd, input int lat, input int mv, input logic [63:0] erd,
                       input logic [1:0] eerr, input logic [31:0] emaddr, input logic [7:0] estrb,
                       input logic [63:0] emwd);
    exp_t e;
    wait_c[s] = w;
    stuck[s]  = stk;
    memrd[s]  = mrd;
    @(negedge clk);
    e.nm = nm; e.rdata = erd; e.err = eerr; e.cyc = cyc + lat; e.mv = mv;
    e.we = we; e.maddr = emaddr; e.strb = estrb; e.mwd = emwd;
    if (s == 0) begin
      chk({nm, "_ready"}, 64'(b32.req_ready), 64'd1);
      q0.push_back(e);
      b32.req_we = we; b32.req_funct3 = f3; b32.req_addr = addr; b32.req_wdata = wd[31:0];
      b32.req_valid = 1'b1;
    end else begin
      chk({nm, "_ready"}, 64'(b64.req_ready), 64'd1);
      q1.push_back(e);
      b64.req_we = we; b64.req_funct3 = f3; b64.req_addr = addr; b64.req_wdata = wd;
      b64.req_valid = 1'b1;
    end
    @(negedge clk);
    // Scramble the request inputs after acceptance; the unit must ignore them.
    if (s == 0) begin
      b32.req_valid = 1'b0; b32.req_we = ~we; b32.req_funct3 = 3'b111;
      b32.req_addr = ~addr; b32.req_wdata = ~wd[31:0];
      chk({nm, "_busy"}, 64'(b32.busy), 64'd1);
    end else begin
      b64.req_valid = 1'b0; b64.req_we = ~we; b64.req_funct3 = 3'b111;
      b64.req_addr = ~addr; b64.req_wdata = ~wd;
      chk({nm, "_busy"}, 64'(b64.busy), 64'd1);
    end
    for (int i = 0; i < 64; i++) begin
      if (qsize(s) == 0) break;
      @(negedge clk);
    end
    if (qsize(s) != 0) begin
      chk({nm, "_no_resp"}, 64'd0, 64'd1);
      if (s == 0) q0.delete(); else q1.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    b32.req_valid = 1'b0; b32.req_we = 1'b0; b32.req_funct3 = '0; b32.req_addr = '0;
    b32.req_wdata = '0; b32.mem_ready = 1'b0; b32.mem_rdata = '0;
    b64.req_valid = 1'b0; b64.req_we = 1'b0; b64.req_funct3 = '0; b64.req_addr = '0;
    b64.req_wdata = '0; b64.mem_ready = 1'b0; b64.mem_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      wait_c[i] = 0; stuck[i] = 1'b0; memrd[i] = '0; mvc[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(b32.req_ready), 64'd1);
    chk("rst_busy", 64'(b32.busy), 64'd0);
    chk("rst_mem_valid", 64'(b32.mem_valid), 64'd0);
    chk("rst_resp_valid", 64'(b32.resp_valid), 64'd0);
    chk("rst_wstrb", 64'(b32.mem_wstrb), 64'd0);
    chk("rst_resp_err", 64'(b32.resp_err), 64'd0);
    chk("rst64_req_ready", 64'(b64.req_ready), 64'd1);
    chk("rst64_mem_addr", 64'(b64.mem_addr), 64'd0);
    reset_n = 1'b1;

    // DATA_W=32 directed vectors
    issue(0, "sb103", 1, 3'b000, 32'h103, 64'hA5, 0, 0, 0, 2, 1, 0, 2'b00, 32'h100, 8'h8, 64'hA500_0000);
    issue(0, "lh202", 0, 3'b001, 32'h202, 0, 2, 0, 64'h8001_1234, 4, 3, 64'hFFFF_8001, 2'b00, 32'h200, 8'h0, 0);
    issue(0, "lhu202", 0, 3'b101, 32'h202, 0, 2, 0, 64'h8001_1234, 4, 3, 64'h0000_8001, 2'b00, 32'h200, 8'h0, 0);
    issue(0, "lb301", 0, 3'b000, 32'h301, 0, 0, 0, 64'h1234_80FF, 2, 1, 64'hFFFF_FF80, 2'b00, 32'h300, 8'h0, 0);
    issue(0, "lbu303", 0, 3'b100, 32'h303, 0, 1, 0, 64'h7F00_0000, 3, 2, 64'h0000_007F, 2'b00, 32'h300, 8'h0, 0);
    issue(0, "sh202", 1, 3'b001, 32'h202, 64'hBEEF, 1, 0, 0, 3, 2, 0, 2'b00, 32'h200, 8'hC, 64'hBEEF_0000);
    issue(0, "sw400", 1, 3'b010, 32'h400, 64'hDEAD_BEEF, 0, 0, 0, 2, 1, 0, 2'b00, 32'h400, 8'hF, 64'hDEAD_BEEF);
    issue(0, "lw404", 0, 3'b010, 32'h404, 0, 3, 0, 64'h89AB_CDEF, 5, 4, 64'h89AB_CDEF, 2'b00, 32'h404, 8'h0, 0);
    issue(0, "sw101_mis", 1, 3'b010, 32'h101, 64'h1111, 0, 0, 0, 1, 0, 0, 2'b01, 0, 0, 0);
    issue(0, "lh201_mis", 0, 3'b001, 32'h201, 0, 0, 0, 0, 1, 0, 0, 2'b01, 0, 0, 0);
    issue(0, "f3_011_ill", 0, 3'b011, 32'h100, 0, 0, 0, 0, 1, 0, 0, 2'b11, 0, 0, 0);
    issue(0, "f3_111_ill", 0, 3'b111, 32'h100, 0, 0, 0, 0, 1, 0, 0, 2'b11, 0, 0, 0);
    issue(0, "lw_timeout", 0, 3'b010, 32'h500, 0, 0, 1, 0, 9, 8, 0, 2'b10, 32'h500, 8'h0, 0);
    issue(0, "lw_ready_at_limit", 0, 3'b010, 32'h500, 0, 7, 0, 64'h1234_5678, 9, 8, 64'h1234_5678, 2'b00, 32'h500, 8'h0, 0);

    // DATA_W=64 directed vectors
    issue(1, "sw0C", 1, 3'b010, 32'h0C, 64'h1122_3344, 0, 0, 0, 2, 1, 0, 2'b00, 32'h08, 8'hF0, 64'h1122_3344_0000_0000);
    issue(1, "lwu0C", 0, 3'b110, 32'h0C, 0, 1, 0, 64'hF000_0001_0000_0000, 3, 2, 64'h0000_0000_F000_0001, 2'b00, 32'h08, 8'h0, 0);
    issue(1, "lw0C", 0, 3'b010, 32'h0C, 0, 0, 0, 64'hF000_0001_0000_0000, 2, 1, 64'hFFFF_FFFF_F000_0001, 2'b00, 32'h08, 8'h0, 0);
    issue(1, "sd10", 1, 3'b011, 32'h10, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 2, 1, 0, 2'b00, 32'h10, 8'hFF, 64'h0123_4567_89AB_CDEF);
    issue(1, "ld18", 0, 3'b011, 32'h18, 0, 2, 0, 64'h8000_0000_0000_0001, 4, 3, 64'h8000_0000_0000_0001, 2'b00, 32'h18, 8'h0, 0);
    issue(1, "lh06", 0, 3'b001, 32'h06, 0, 0, 0, 64'hABCD_0000_0000_0000, 2, 1, 64'hFFFF_FFFF_FFFF_ABCD, 2'b00, 32'h00, 8'h0, 0);
    issue(1, "sw0A_mis", 1, 3'b010, 32'h0A, 64'h5555, 0, 0, 0, 1, 0, 0, 2'b01, 0, 0, 0);
    issue(1, "f3_111_ill64", 0, 3'b111, 32'h10, 0, 0, 0, 0, 1, 0, 0, 2'b11, 0, 0, 0);

    // Reset during ACCESS: the access is abandoned with no response.
    stuck[0] = 1'b1;
    wait_c[0] = 0;
    @(negedge clk);
    b32.req_we = 1'b0; b32.req_funct3 = 3'b010; b32.req_addr = 32'h600; b32.req_valid = 1'b1;
    @(negedge clk);
    b32.req_valid = 1'b0;
    chk("abort_in_access", 64'(b32.mem_valid), 64'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_mem_valid", 64'(b32.mem_valid), 64'd0);
    chk("abort_busy", 64'(b32.busy), 64'd0);
    chk("abort_req_ready", 64'(b32.req_ready), 64'd1);
    @(negedge clk);
    chk("abort_resp_valid", 64'(b32.resp_valid), 64'd0);
    #2 reset_n = 1'b1;
    stuck[0] = 1'b0;
    issue(0, "lw_after_reset", 0, 3'b010, 32'h604, 0, 1, 0, 64'hCAFE_F00D, 3, 2, 64'hCAFE_F00D, 2'b00, 32'h604, 8'h0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
